// File: rtl/instr_mem_ld_pkg.sv
// instr_mem_ld_pkg: shared types, defaults and the parity helper for the
// fdt16 instruction memory with program-load port.
// Optional parity storage is enabled with the INSTR_MEM_PARITY_EN macro.
package instr_mem_ld_pkg;

  // Load-session states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  // Instruction returned at reset and for out-of-range fetches.
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int PAR_MAX_W = 64;

  // Even-parity bit: makes the total count of ones (word + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/instr_mem_ld_if.sv
// instr_mem_ld_if: fetch and program-load signals of the instruction memory.
// The parity_err signal exists only when INSTR_MEM_PARITY_EN is defined.
interface instr_mem_ld_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
);
  // fetch side
  logic              fetch_en;
  logic [ADDR_W-1:0] program_counter;
  logic [DATA_W-1:0] data_out;
  logic              fetch_valid;
  // load side
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              loading;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              load_err;
`ifdef INSTR_MEM_PARITY_EN
  logic              parity_err;
`endif

  // Fetch stage and loader drive requests; memory answers.
  modport master (
    output fetch_en, program_counter, load_start, load_base,
           load_valid, load_data, load_last,
    input  data_out, fetch_valid, load_ready, loading, load_done,
           load_count, load_err
`ifdef INSTR_MEM_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  fetch_en, program_counter, load_start, load_base,
           load_valid, load_data, load_last,
    output data_out, fetch_valid, load_ready, loading, load_done,
           load_count, load_err
`ifdef INSTR_MEM_PARITY_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/instr_mem_ld_array.sv
// instr_mem_ld_array: simple dual-port storage, one write port and one
// registered read port. Storage itself is never reset; only the read
// register returns to RST_WORD. rd_nop_i substitutes RST_WORD for a read.
module instr_mem_ld_array #(
  parameter int             WORD_W   = 16,
  parameter int             ADDR_W   = 11,
  parameter int             DEPTH    = 2048,
  parameter logic [WORD_W-1:0] RST_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              rd_nop_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  logic [WORD_W-1:0] mem_q [0:DEPTH-1];
  logic [WORD_W-1:0] rd_data_q;

  // Write port: caller guarantees wr_addr_i < DEPTH when wr_en_i is set.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= RST_WORD;
    end else if (rd_en_i) begin
      rd_data_q <= rd_nop_i ? RST_WORD : mem_q[rd_addr_i];
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_mem_ld.sv
// instr_mem_ld: synchronous-read instruction memory for the fdt16 core with
// a valid/ready program-load port. Loads stream into consecutive addresses
// from load_base; fetch is blocked while a load session is active.
// Define INSTR_MEM_PARITY_EN to store an even-parity bit per word and
// report mismatches on parity_err.
module instr_mem_ld
  import instr_mem_ld_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 11,
  parameter int                DEPTH     = 2048,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_mem_ld_if.slave bus
);

`ifdef INSTR_MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
  localparam logic [WORD_W-1:0] RST_WORD =
    {even_parity(PAR_MAX_W'(NOP_INSTR)), NOP_INSTR};
`else
  localparam int WORD_W = DATA_W;
  localparam logic [WORD_W-1:0] RST_WORD = NOP_INSTR;
`endif

  // Addresses and counts carry one extra bit so that running past the top
  // of the address space is seen as overflow rather than wrapping to 0.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  load_state_e       state_q;
  logic [ADDR_W:0]   addr_q;
  logic [ADDR_W:0]   addr_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              err_q;
  logic              ready_q;
  logic              loading_q;
  logic              done_q;
  logic              fetch_valid_q;

  logic              accept_s;
  logic              ovf_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic              rd_nop_s;
  logic [WORD_W-1:0] wr_word_s;
  logic [WORD_W-1:0] rd_word_s;

  // Beat acceptance, overflow detection, saturating increments, fetch gating.
  always_comb begin
    accept_s = (state_q == ST_LOAD) && bus.load_valid;
    ovf_s    = (addr_q >= DEPTH_C);
    wr_en_s  = accept_s && !ovf_s;
    addr_d   = (addr_q == CNT_MAX) ? addr_q : addr_q + ONE_C;
    count_d  = (count_q == CNT_MAX) ? count_q : count_q + ONE_C;
    rd_en_s  = !loading_q && bus.fetch_en;
    rd_nop_s = ({1'b0, bus.program_counter} >= DEPTH_C);
  end

`ifdef INSTR_MEM_PARITY_EN
  assign wr_word_s = {even_parity(PAR_MAX_W'(bus.load_data)), bus.load_data};
`else
  assign wr_word_s = bus.load_data;
`endif

  instr_mem_ld_array #(
    .WORD_W   (WORD_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RST_WORD (RST_WORD)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (addr_q[ADDR_W-1:0]),
    .wr_data_i (wr_word_s),
    .rd_en_i   (rd_en_s),
    .rd_nop_i  (rd_nop_s),
    .rd_addr_i (bus.program_counter),
    .rd_data_o (rd_word_s)
  );

  // Load-session FSM with its address/count/error registers and the
  // registered handshake and fetch-valid outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      ready_q       <= 1'b0;
      loading_q     <= 1'b0;
      done_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_valid_q <= rd_en_s;
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.load_start) begin
            state_q   <= ST_LOAD;
            addr_q    <= {1'b0, bus.load_base};
            count_q   <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            loading_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            addr_q  <= addr_d;
            count_q <= count_d;
            if (ovf_s) begin
              err_q <= 1'b1;
            end else begin
              err_q <= err_q;
            end
            if (bus.load_last) begin
              state_q   <= ST_DONE;
              ready_q   <= 1'b0;
              loading_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end else begin
            state_q <= ST_LOAD;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          ready_q   <= 1'b0;
          loading_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out    = rd_word_s[DATA_W-1:0];
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.load_ready  = ready_q;
  assign bus.loading     = loading_q;
  assign bus.load_done   = done_q;
  assign bus.load_count  = count_q;
  assign bus.load_err    = err_q;

`ifdef INSTR_MEM_PARITY_EN
  // A stored word plus its parity bit must have even weight; out-of-range
  // fetches return RST_WORD, which is always consistent.
  assign bus.parity_err = fetch_valid_q && (^rd_word_s);
`endif

endmodule

// File: tb/tb_instr_mem_ld.sv
// tb_instr_mem_ld: directed bench for instr_mem_ld with a high-level model
// (sparse memory + session flags) compared every cycle, plus literal checks.
// The parity section is compiled only when INSTR_MEM_PARITY_EN is defined.
module tb_instr_mem_ld;

  localparam int          DW  = 16;
  localparam int          AW  = 11;
  localparam int          DEP = 2000;
  localparam logic [15:0] NOP = 16'h0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_mem_ld_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  instr_mem_ld #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .DEPTH     (DEP),
    .NOP_INSTR (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [15:0] m_mem   [0:2047];
  bit          m_known [0:2047];
  bit          m_sess  = 1'b0;
  bit          m_done  = 1'b0;
  int          m_addr  = 0;
  int          m_cnt   = 0;
  bit          m_err   = 1'b0;
  logic [15:0] m_dout  = 16'h0000;
  bit          m_dknown = 1'b0;
  bit          m_fv    = 1'b0;

  logic [15:0] bq [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: apply the behavioural rules to the inputs seen at each rising edge.
  initial begin
    for (int i = 0; i < 2048; i++) m_known[i] = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_sess = 1'b0; m_done = 1'b0; m_cnt = 0; m_err = 1'b0;
        m_dout = NOP; m_dknown = 1'b1; m_fv = 1'b0;
      end else begin
        if (!m_sess && bus.fetch_en) begin
          m_fv = 1'b1;
          if (int'(bus.program_counter) >= DEP) begin
            m_dout = NOP; m_dknown = 1'b1;
          end else begin
            m_dout = m_mem[bus.program_counter];
            m_dknown = m_known[bus.program_counter];
          end
        end else begin
          m_fv = 1'b0;
        end
        if (m_done) begin
          m_done = 1'b0;
        end else if (!m_sess) begin
          if (bus.load_start) begin
            m_sess = 1'b1; m_addr = int'(bus.load_base); m_cnt = 0; m_err = 1'b0;
          end
        end else if (bus.load_valid) begin
          if (m_addr < DEP) begin
            m_mem[m_addr] = bus.load_data; m_known[m_addr] = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          m_addr++;
          if (m_cnt < (1 << AW)) m_cnt++;
          if (bus.load_last) begin
            m_sess = 1'b0; m_done = 1'b1;
          end
        end
      end
    end
  end

  // Compare: every falling edge after the first rising edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (m_dknown) check("m_data_out", 32'(bus.data_out), 32'(m_dout));
      check("m_fetch_valid", 32'(bus.fetch_valid), 32'(m_fv));
      check("m_load_ready",  32'(bus.load_ready),  32'(m_sess));
      check("m_loading",     32'(bus.loading),     32'(m_sess));
      check("m_load_done",   32'(bus.load_done),   32'(m_done));
      check("m_load_count",  32'(bus.load_count),  32'(m_cnt));
      check("m_load_err",    32'(bus.load_err),    32'(m_err));
    end
  end

  task automatic do_fetch(input logic [10:0] pc, input logic [15:0] exp, input string nm);
    bus.fetch_en = 1'b1;
    bus.program_counter = pc;
    @(negedge clk);
    check(nm, 32'(bus.data_out), 32'(exp));
    check({nm, "_fv"}, 32'(bus.fetch_valid), 32'd1);
    bus.fetch_en = 1'b0;
  endtask

  // Open a session at base and send n beats (from bq, else the beat index);
  // gap inserts an idle cycle with junk data before each beat.
  task automatic run_load(input logic [10:0] base, input int n, input bit gap, input bit with_last);
    bus.load_start = 1'b1;
    bus.load_base  = base;
    @(negedge clk);
    bus.load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        bus.load_valid = 1'b0;
        bus.load_data  = 16'hDEAD;
        @(negedge clk);
      end
      bus.load_valid = 1'b1;
      bus.load_data  = (i < bq.size()) ? bq[i] : 16'(i);
      bus.load_last  = with_last && (i == n - 1);
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.fetch_en = 1'b1;        bus.program_counter = 11'd0;
    bus.load_start = 1'b0;      bus.load_base = 11'd0;
    bus.load_valid = 1'b0;      bus.load_data = 16'h0000;
    bus.load_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    check("rst_loading", 32'(bus.loading), 32'd0);
    check("rst_load_ready", 32'(bus.load_ready), 32'd0);
    check("rst_load_count", 32'(bus.load_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_fetch_valid", 32'(bus.fetch_valid), 32'd1);
    bus.fetch_en = 1'b0;

    // three-beat load from 0; first fetch lands in the DONE cycle
    bq = '{16'h1234, 16'h5678, 16'hABCD};
    run_load(11'd0, 3, 1'b0, 1'b1);
    check("ld1_done", 32'(bus.load_done), 32'd1);
    check("ld1_count", 32'(bus.load_count), 32'd3);
    do_fetch(11'd1, 16'h5678, "ld1_pc1");
    do_fetch(11'd0, 16'h1234, "ld1_pc0");
    do_fetch(11'd2, 16'hABCD, "ld1_pc2");

    // toggling load_valid
    bq = '{16'h1111, 16'h2222};
    run_load(11'd10, 2, 1'b1, 1'b1);
    check("ld2_count", 32'(bus.load_count), 32'd2);
    @(negedge clk);
    do_fetch(11'd10, 16'h1111, "ld2_pc10");
    do_fetch(11'd11, 16'h2222, "ld2_pc11");

    // overflow past DEPTH-1
    bq = '{16'hAAAA, 16'hBBBB};
    run_load(11'(DEP - 1), 2, 1'b0, 1'b1);
    check("ovf_err", 32'(bus.load_err), 32'd1);
    check("ovf_count", 32'(bus.load_count), 32'd2);
    do_fetch(11'(DEP - 1), 16'hAAAA, "ovf_top");
    do_fetch(11'd0, 16'h1234, "ovf_mem0");
    do_fetch(11'(DEP), NOP, "oor_fetch");
    check("ovf_err_sticky", 32'(bus.load_err), 32'd1);

    // overflow at the very top of the address space must not wrap to 0
    bq = '{16'hCCCC, 16'hDDDD};
    run_load(11'd2047, 2, 1'b0, 1'b1);
    check("wrap_err", 32'(bus.load_err), 32'd1);
    @(negedge clk);
    do_fetch(11'd0, 16'h1234, "wrap_mem0");
    do_fetch(11'd1, 16'h5678, "wrap_mem1");

    // fetch held during a session, ignored load_start, reset mid-session
    bus.fetch_en = 1'b1; bus.program_counter = 11'd1;
    bq = '{16'h7777, 16'h8888};
    run_load(11'd20, 2, 1'b0, 1'b0);
    bus.load_start = 1'b1; bus.load_base = 11'd100;
    bus.load_valid = 1'b1; bus.load_data = 16'h5555;
    @(negedge clk);
    bus.load_start = 1'b0; bus.load_valid = 1'b0;
    check("sess_fv", 32'(bus.fetch_valid), 32'd0);
    check("sess_loading", 32'(bus.loading), 32'd1);
    check("sess_count", 32'(bus.load_count), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_loading", 32'(bus.loading), 32'd0);
    check("mid_rst_ready", 32'(bus.load_ready), 32'd0);
    rst_n = 1'b1; bus.fetch_en = 1'b0;
    @(negedge clk);
    do_fetch(11'd22, 16'h5555, "mid_pc22");
    do_fetch(11'd20, 16'h7777, "mid_pc20");
    do_fetch(11'd21, 16'h8888, "mid_pc21");

    // load_count saturation with a long out-of-range stream
    bq.delete();
    run_load(11'(DEP), 2050, 1'b0, 1'b1);
    check("sat_count", 32'(bus.load_count), 32'd2048);
    check("sat_err", 32'(bus.load_err), 32'd1);
    @(negedge clk);
    do_fetch(11'd0, 16'h1234, "sat_mem0");

`ifdef INSTR_MEM_PARITY_EN
    bq = '{16'h0003};
    run_load(11'd5, 1, 1'b0, 1'b1);
    @(negedge clk);
    dut.u_array.mem_q[5][DW] = ~dut.u_array.mem_q[5][DW];
    do_fetch(11'd5, 16'h0003, "par_pc5");
    check("par_err_hit", 32'(bus.parity_err), 32'd1);
    @(negedge clk);
    check("par_err_idle", 32'(bus.parity_err), 32'd0);
    do_fetch(11'd0, 16'h1234, "par_pc0");
    check("par_err_clean", 32'(bus.parity_err), 32'd0);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
